key_event_decoder: RTL and testbench

- Sits downstream of the key debouncer and consumes its one-cycle press pulse plus the raw active-low key pin.
- Classifies each press gesture as short press, long press or double click.
- Emits exactly one single-cycle event pulse per gesture to the application logic (menu/mode control).

---
 rtl/key_pkg.sv | 18 +
 rtl/key_event_decoder_if.sv | 23 ++
 rtl/key_release_detect.sv | 36 +++
 rtl/key_event_decoder.sv | 103 ++++++++++
 tb/tb_key_event_decoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and default timing for the key event decoder
package key_pkg;

   // Gesture classifier states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HELD  = 3'd1,
      LONG  = 3'd2,
      GAP   = 3'd3,
      HELD2 = 3'd4
   } keyState_t;

   // Default timing at a 50 MHz CLK
   localparam int HOLD_1S   = 50000000;
   localparam int GAP_300MS = 15000000;
   localparam int REL_10MS  = 500000;

endpackage

// File: rtl/key_event_decoder_if.sv
// rtl/key_event_decoder_if.sv - key press inputs and gesture event outputs
interface key_event_decoder_if;

   logic KeyPulse;
   logic PinIn;
   logic ShortOut;
   logic LongOut;
   logic DoubleOut;
   logic Busy;

   // Application side: drives the key signals, receives events
   modport master (
      output KeyPulse, PinIn,
      input  ShortOut, LongOut, DoubleOut, Busy
   );

   // Decoder side
   modport slave (
      input  KeyPulse, PinIn,
      output ShortOut, LongOut, DoubleOut, Busy
   );

endinterface

// File: rtl/key_release_detect.sv
// rtl/key_release_detect.sv - confirms key release after RELEASE_CYCLES steady high samples
module key_release_detect
   import key_pkg::*;
#(
   parameter int RELEASE_CYCLES = REL_10MS
) (
   input  logic CLK,
   input  logic RST,
   input  logic PinIn,
   output logic Released
);

   localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES - 1);

   logic             pinReg;
   logic [REL_W-1:0] relCnt;

   // Register the raw pin once, then count consecutive high samples (saturating)
   always_ff @(posedge CLK) begin
      if (RST) begin
         pinReg <= 1'b1;
         relCnt <= '0;
      end else begin
         pinReg <= PinIn;
         if (!pinReg) begin
            relCnt <= '0;
         end else if (relCnt != REL_MAX) begin
            relCnt <= relCnt + REL_W'(1);
         end
      end
   end

   assign Released = pinReg && (relCnt == REL_MAX);

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced key presses into short, long and double events
module key_event_decoder
   import key_pkg::*;
#(
   parameter int HOLD_CYCLES    = HOLD_1S,
   parameter int GAP_CYCLES     = GAP_300MS,
   parameter int RELEASE_CYCLES = REL_10MS,
   parameter int CNT_W          = 26
) (
   input  logic                CLK,
   input  logic                RST,
   key_event_decoder_if.slave  keyIf
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   keyState_t        state, stateNext;
   logic [CNT_W-1:0] holdCnt, holdNext;
   logic [CNT_W-1:0] gapCnt, gapNext;
   logic             shortNext, longNext, doubleNext;
   logic             shortReg, longReg, doubleReg;
   logic             released;

   key_release_detect #(
      .RELEASE_CYCLES (RELEASE_CYCLES)
   ) u_release (
      .CLK      (CLK),
      .RST      (RST),
      .PinIn    (keyIf.PinIn),
      .Released (released)
   );

   // Next state, counters and event decisions; long beats release, KeyPulse beats gap expiry
   always_comb begin
      stateNext  = state;
      holdNext   = holdCnt;
      gapNext    = gapCnt;
      shortNext  = 1'b0;
      longNext   = 1'b0;
      doubleNext = 1'b0;
      case (state)
         IDLE: begin
            if (keyIf.KeyPulse) begin
               stateNext = HELD;
               holdNext  = '0;
            end
         end
         HELD: begin
            holdNext = holdCnt + CNT_W'(1);
            if (holdCnt == HOLD_LAST) begin
               longNext  = 1'b1;
               stateNext = LONG;
            end else if (released) begin
               stateNext = GAP;
               gapNext   = '0;
            end
         end
         LONG: begin
            if (released) stateNext = IDLE;
         end
         GAP: begin
            gapNext = gapCnt + CNT_W'(1);
            if (keyIf.KeyPulse) begin
               doubleNext = 1'b1;
               stateNext  = HELD2;
            end else if (gapCnt == GAP_LAST) begin
               shortNext = 1'b1;
               stateNext = IDLE;
            end
         end
         HELD2: begin
            if (released) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State, counters and one-cycle event registers; reset aborts any gesture silently
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         holdCnt   <= '0;
         gapCnt    <= '0;
         shortReg  <= 1'b0;
         longReg   <= 1'b0;
         doubleReg <= 1'b0;
      end else begin
         state     <= stateNext;
         holdCnt   <= holdNext;
         gapCnt    <= gapNext;
         shortReg  <= shortNext;
         longReg   <= longNext;
         doubleReg <= doubleNext;
      end
   end

   assign keyIf.ShortOut  = shortReg;
   assign keyIf.LongOut   = longReg;
   assign keyIf.DoubleOut = doubleReg;
   assign keyIf.Busy      = (state != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - randomized gesture scoreboard bench for key_event_decoder
module tb_key_event_decoder;

   localparam int HOLD = 20;
   localparam int GAP  = 10;
   localparam int RC   = 4;
   localparam int MAXG = 160;
   localparam int PAD  = 4;
   localparam int EV_SHORT = 0;
   localparam int EV_LONG = 1;
   localparam int EV_DOUBLE = 2;

   logic CLK = 1'b0;
   logic RST;

   key_event_decoder_if keyIf ();

   key_event_decoder #(
      .HOLD_CYCLES    (HOLD),
      .GAP_CYCLES     (GAP),
      .RELEASE_CYCLES (RC),
      .CNT_W          (8)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .keyIf (keyIf)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int kind;
      int cyc;
   } evt_t;

   evt_t expQ[$];
   int   cyc = 0;
   int   nChecks = 0;
   int   nFails = 0;

   bit kp   [MAXG];
   bit pin  [MAXG];
   bit rstA [MAXG];
   int idleAt;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // A release is recognised in gesture cycle c when the pin read high in all RC preceding cycles
   function automatic bit relAt(input int c);
      for (int i = c - RC; i < c; i++) begin
         if (i >= 0 && i < MAXG && !pin[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int firstRel(input int from, input int upto);
      for (int c = from; c <= upto; c++) begin
         if (relAt(c)) return c;
      end
      return -1;
   endfunction

   // Gesture-level reference: derive event kind/time and the cycle the decoder is idle again
   task automatic modelGesture(input int base);
      int r, k, evKind, evCyc, rstC, ex;
      evt_t e;
      rstC = -1;
      for (int c = 0; c < MAXG; c++) begin
         if (rstA[c] && rstC < 0) rstC = c;
      end
      r = firstRel(1, HOLD - 1);
      if (r < 0) begin
         evKind = EV_LONG;
         evCyc  = HOLD + 1;
         ex     = firstRel(HOLD + 1, MAXG - 1);
         idleAt = ex + 1;
      end else begin
         k = -1;
         for (int c = r + 1; c <= r + GAP; c++) begin
            if (kp[c] && k < 0) k = c;
         end
         if (k < 0) begin
            evKind = EV_SHORT;
            evCyc  = r + GAP + 1;
            idleAt = r + GAP + 1;
         end else begin
            evKind = EV_DOUBLE;
            evCyc  = k + 1;
            ex     = firstRel(k + 1, MAXG - 1);
            idleAt = ex + 1;
         end
      end
      if (rstC >= 0 && idleAt > rstC + 1) idleAt = rstC + 1;
      if (rstC < 0 || evCyc <= rstC) begin
         e.kind = evKind;
         e.cyc  = base + evCyc;
         expQ.push_back(e);
      end
   endtask

   task automatic clearStim();
      for (int i = 0; i < MAXG; i++) begin
         kp[i]   = 1'b0;
         pin[i]  = 1'b1;
         rstA[i] = 1'b0;
      end
   endtask

   // Press held for lowLen cycles; optional 1,1,1,0 bounce before the final release
   task automatic genPress(input int lowLen, input bit bounce);
      clearStim();
      kp[0] = 1'b1;
      for (int i = 0; i < lowLen; i++) pin[i] = 1'b0;
      if (bounce) pin[lowLen + 3] = 1'b0;
   endtask

   task automatic genDouble(input int lowLen, input int d, input int lowLen2, input bit extra);
      int r, k;
      genPress(lowLen, 1'b0);
      r = firstRel(1, HOLD - 1);
      k = r + d;
      kp[k] = 1'b1;
      for (int i = k; i < k + lowLen2; i++) pin[i] = 1'b0;
      if (extra) kp[k + 2] = 1'b1;
   endtask

   task automatic runGesture();
      int base;
      @(posedge CLK);
      #1;
      base = cyc;
      modelGesture(base);
      for (int t = 0; t < idleAt + PAD; t++) begin
         if (t > 0) begin
            @(posedge CLK);
            #1;
         end
         keyIf.KeyPulse = kp[t];
         keyIf.PinIn    = pin[t];
         RST            = rstA[t];
         @(negedge CLK);
         check("busy", int'(keyIf.Busy), int'(t >= 1 && t < idleAt));
      end
      @(posedge CLK);
      #1;
      keyIf.KeyPulse = 1'b0;
      keyIf.PinIn    = 1'b1;
      RST            = 1'b0;
   endtask

   // Monitor: every event pulse must match the head of the expected queue in kind and cycle
   always @(negedge CLK) begin
      int hi, kind;
      evt_t e;
      hi = int'(keyIf.ShortOut) + int'(keyIf.LongOut) + int'(keyIf.DoubleOut);
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
         e = expQ.pop_front();
         check("missed_event_kind", -1, e.kind);
      end
      if (hi > 0) begin
         check("events_onehot", hi, 1);
         kind = keyIf.ShortOut ? EV_SHORT : (keyIf.LongOut ? EV_LONG : EV_DOUBLE);
         if (expQ.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
         end else begin
            e = expQ.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int kindSel, l, l2, d;
      RST            = 1'b1;
      keyIf.KeyPulse = 1'b0;
      keyIf.PinIn    = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset_short", int'(keyIf.ShortOut), 0);
      check("reset_long", int'(keyIf.LongOut), 0);
      check("reset_double", int'(keyIf.DoubleOut), 0);
      check("reset_busy", int'(keyIf.Busy), 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (RC + 2) @(posedge CLK);

      // Directed: short, long with ignored pulse, double, bounce, boundaries, reset abort
      genPress(8, 1'b0);                   runGesture();
      genPress(40, 1'b0); kp[HOLD + 3] = 1'b1; runGesture();
      genDouble(8, 5, 6, 1'b1);            runGesture();
      genPress(8, 1'b1);                   runGesture();
      genDouble(8, GAP, 5, 1'b0);          runGesture();
      genDouble(3, 1, 2, 1'b0);            runGesture();
      genPress(HOLD - RC, 1'b0);           runGesture();
      genPress(HOLD - RC - 1, 1'b0); kp[3] = 1'b1; runGesture();
      genPress(30, 1'b0); rstA[16] = 1'b1; runGesture();
      genPress(8, 1'b0);                   runGesture();

      // Randomized gestures
      for (int n = 0; n < 30; n++) begin
         kindSel = $urandom_range(0, 3);
         case (kindSel)
            0: begin
               l = $urandom_range(1, HOLD - RC - 1);
               genPress(l, 1'b0);
               if ($urandom_range(0, 1) == 1) kp[2] = 1'b1;
            end
            1: begin
               l = $urandom_range(HOLD - RC, 40);
               genPress(l, 1'b0);
               if (l >= 20 && $urandom_range(0, 1) == 1) kp[HOLD + 3] = 1'b1;
            end
            2: begin
               l  = $urandom_range(1, HOLD - RC - 1);
               d  = $urandom_range(1, GAP);
               l2 = $urandom_range(1, 12);
               genDouble(l, d, l2, 1'($urandom_range(0, 1)));
            end
            default: begin
               l = $urandom_range(1, 30);
               genPress(l, 1'b1);
            end
         endcase
         runGesture();
      end

      repeat (5) @(posedge CLK);
      @(negedge CLK);
      check("pending_events", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected finish before limit");
      $fatal(1);
   end

endmodule
